// File: rtl/gpio_input_pkg.sv
// -----------------------------------------------------------------------------
// gpio_input_pkg
// Shared definitions for the debounced GPIO input block and the memory-stage
// address decode that drives it.
//   SEL_*          : register select encodings carried on the sel bus
//   TICK_CNT_W     : width of the debounce tick counter (covers TICK_DIV<=65535)
//   qualified_edge : decides whether a debounced transition is reportable
// -----------------------------------------------------------------------------
package gpio_input_pkg;

    localparam logic [1:0] SEL_DATA     = 2'd0;
    localparam logic [1:0] SEL_EDGE     = 2'd1;
    localparam logic [1:0] SEL_MASK     = 2'd2;
    localparam logic [1:0] SEL_POLARITY = 2'd3;

    localparam int TICK_CNT_W = 16;

    // Called only when a bit is actually changing: the new level matching the
    // polarity bit means a rising edge with POLARITY=1 or a falling edge with
    // POLARITY=0.
    function automatic logic qualified_edge(input logic new_val, input logic pol);
        return (new_val == pol);
    endfunction

endpackage

// File: rtl/gpio_input_if.sv
// -----------------------------------------------------------------------------
// gpio_input_if
// Register access bus between the memory stage and gpio_input.
//   sel     : register select (see gpio_input_pkg SEL_*)
//   we      : write strobe for the selected register
//   wr_data : write data
//   rd_data : registered read data (one-cycle latency)
//   irq     : registered interrupt request
// master = memory stage side, slave = gpio_input side.
// -----------------------------------------------------------------------------
interface gpio_input_if #(
    parameter int WORD_SIZE = 32
) ();
    import gpio_input_pkg::*;

    logic [1:0]           sel;
    logic                 we;
    logic [WORD_SIZE-1:0] wr_data;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 irq;

    modport master (
        output sel,
        output we,
        output wr_data,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  sel,
        input  we,
        input  wr_data,
        output rd_data,
        output irq
    );

endinterface

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// Per-pin front end: 2-flop synchronizer followed by the debounce sample
// history clocked by the shared tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle sample strobe from the parent's tick counter
//   pin        : raw asynchronous pin
//   samples    : 3-sample window seen on a tick, [0] = sample taken this tick,
//                [2] = oldest; only meaningful while tick is high
// -----------------------------------------------------------------------------
module gpio_debounce
    import gpio_input_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       pin,
    output logic [2:0] samples
);

    logic [1:0] sync_q, sync_d;
    logic [1:0] hist_q, hist_d;

    // The third stage of the window is the synchronized level being captured
    // on this tick, so DATA can update on the same tick that completes three
    // agreeing samples instead of one tick later.
    always_comb begin
        sync_d = {sync_q[0], pin};
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[0], sync_q[1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign samples = {hist_q, sync_q[1]};

endmodule

// File: rtl/gpio_input.sv
// -----------------------------------------------------------------------------
// gpio_input
// Debounced GPIO input bank with sticky, polarity-selectable edge capture,
// interrupt masking and a one-cycle-latency register read port.
//   clk      : sole clock
//   rst_n    : asynchronous active-low reset
//   pins     : WORD_SIZE external pins, asynchronous to clk
//   bus      : register bus (slave side): sel, we, wr_data in; rd_data, irq out
// Registers: DATA (debounced level, read-only), EDGE (sticky, W1C),
//            MASK (irq enable), POLARITY (1 = rising, 0 = falling).
// -----------------------------------------------------------------------------
module gpio_input
    import gpio_input_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int TICK_DIV  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] pins,
    gpio_input_if.slave          bus
);

    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_DIV - 1);

    logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  tick;

    logic [WORD_SIZE-1:0]  data_q, data_d;
    logic [WORD_SIZE-1:0]  edge_q, edge_d;
    logic [WORD_SIZE-1:0]  mask_q, mask_d;
    logic [WORD_SIZE-1:0]  pol_q, pol_d;
    logic [WORD_SIZE-1:0]  rd_data_q, rd_data_d;
    logic                  irq_q, irq_d;

    logic [WORD_SIZE-1:0]  edge_set;
    logic [WORD_SIZE-1:0]  edge_clr;
    logic [2:0]            samples [WORD_SIZE];

    // ---------------- tick counter ----------------
    assign tick  = (cnt_q == TICK_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------- per-pin synchronizer + sample history ----------------
    for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_pin
        gpio_debounce u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .pin     (pins[gi]),
            .samples (samples[gi])
        );
    end

    // ---------------- DATA / EDGE ----------------
    always_comb begin
        data_d   = data_q;
        edge_set = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (tick && (samples[i] == 3'b111 || samples[i] == 3'b000)
                     && (samples[i][0] != data_q[i])) begin
                data_d[i]   = samples[i][0];
                edge_set[i] = qualified_edge(samples[i][0], pol_q[i]);
            end
        end
        edge_clr = (bus.we && bus.sel == SEL_EDGE) ? bus.wr_data : '0;
        // Set is applied after clear so a same-cycle collision leaves the bit set.
        edge_d   = (edge_q & ~edge_clr) | edge_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            edge_q <= '0;
        end else begin
            data_q <= data_d;
            edge_q <= edge_d;
        end
    end

    // ---------------- MASK / POLARITY ----------------
    always_comb begin
        mask_d = mask_q;
        pol_d  = pol_q;
        if (bus.we) begin
            case (bus.sel)
                SEL_MASK:     mask_d = bus.wr_data;
                SEL_POLARITY: pol_d  = bus.wr_data;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            pol_q  <= '1;
        end else begin
            mask_q <= mask_d;
            pol_q  <= pol_d;
        end
    end

    // ---------------- read port / interrupt ----------------
    // Reads sample the current register values, so an EDGE read in the same
    // cycle as a W1C returns the pre-clear contents.
    always_comb begin
        case (bus.sel)
            SEL_DATA: rd_data_d = data_q;
            SEL_EDGE: rd_data_d = edge_q;
            SEL_MASK: rd_data_d = mask_q;
            default:  rd_data_d = pol_q;
        endcase
        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_gpio_input.sv
module tb_gpio_input;
    import gpio_input_pkg::*;

    localparam int WS = 32;
    localparam int TD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WS-1:0] pins = '0;

    int n_vec = 0;
    int n_err = 0;

    gpio_input_if #(.WORD_SIZE(WS)) bus_if ();

    gpio_input #(
        .WORD_SIZE (WS),
        .TICK_DIV  (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // All tasks start and end on a falling edge; inputs change there and
    // outputs are sampled there, half a period away from the active edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input logic [WS-1:0] p);
        @(negedge clk);
        rst_n          = 1'b0;
        pins           = p;
        bus_if.sel     = SEL_DATA;
        bus_if.we      = 1'b0;
        bus_if.wr_data = '0;
        wait_cycles(3);
        rst_n = 1'b1;
    endtask

    task automatic write_reg(input logic [1:0] s, input logic [WS-1:0] d);
        bus_if.sel     = s;
        bus_if.we      = 1'b1;
        bus_if.wr_data = d;
        @(negedge clk);
        bus_if.we      = 1'b0;
        bus_if.wr_data = '0;
    endtask

    task automatic read_reg(input logic [1:0] s, output logic [WS-1:0] v);
        bus_if.sel = s;
        bus_if.we  = 1'b0;
        @(negedge clk);
        v = bus_if.rd_data;
    endtask

    task automatic test_reset();
        logic [WS-1:0] rv;
        bit            found;
        rst_n          = 1'b0;
        pins           = 32'hFFFF_FFFF;
        bus_if.sel     = SEL_DATA;
        bus_if.we      = 1'b0;
        bus_if.wr_data = '0;
        wait_cycles(4);
        n_vec++;
        if (bus_if.rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h expected %h", bus_if.rd_data, 32'h0);
        end
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", bus_if.irq);
        end
        rst_n = 1'b1;
        found = 0;
        for (int c = 1; c <= 2 + 3 * TD + 2 && !found; c++) begin
            @(negedge clk);
            if (bus_if.rd_data === 32'hFFFF_FFFF) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_data_settle: got %h expected ffffffff within %0d cycles",
                     bus_if.rd_data, 2 + 3 * TD + 2);
        end
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_edge_rise: got %h expected ffffffff", rv);
        end
        read_reg(SEL_MASK, rv);
        n_vec++;
        if (rv !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mask: got %h expected 00000000", rv);
        end
        read_reg(SEL_POLARITY, rv);
        n_vec++;
        if (rv !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_polarity: got %h expected ffffffff", rv);
        end
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq_masked: got %b expected 0", bus_if.irq);
        end
    endtask

    task automatic test_debounce();
        logic [WS-1:0] rv;
        apply_reset('0);
        wait_cycles(5);
        pins = 32'h1;
        wait_cycles(TD);
        pins = 32'h0;
        wait_cycles(4 * TD);
        read_reg(SEL_DATA, rv);
        n_vec++;
        if (rv !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_data: got %h expected 00000000", rv);
        end
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_edge: got %h expected 00000000", rv);
        end
        pins = 32'h1;
        wait_cycles(4 * TD);
        read_reg(SEL_DATA, rv);
        n_vec++;
        if (rv !== 32'h1) begin
            n_err++;
            $display("FAIL held_data: got %h expected 00000001", rv);
        end
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h1) begin
            n_err++;
            $display("FAIL held_edge: got %h expected 00000001", rv);
        end
    endtask

    task automatic test_polarity();
        logic [WS-1:0] rv;
        logic          prev_irq;
        bit            found;
        apply_reset('0);
        write_reg(SEL_POLARITY, 32'h0);
        write_reg(SEL_MASK, 32'h1);
        pins = 32'h1;
        wait_cycles(4 * TD);
        read_reg(SEL_DATA, rv);
        n_vec++;
        if (rv !== 32'h1) begin
            n_err++;
            $display("FAIL pol_rise_data: got %h expected 00000001", rv);
        end
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h0) begin
            n_err++;
            $display("FAIL pol_rise_edge: got %h expected 00000000", rv);
        end
        n_vec++;
        if (bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL pol_rise_irq: got %b expected 0", bus_if.irq);
        end
        bus_if.sel = SEL_DATA;
        pins       = 32'h0;
        prev_irq   = bus_if.irq;
        found      = 0;
        for (int c = 0; c < 5 * TD && !found; c++) begin
            @(negedge clk);
            if (bus_if.rd_data[0] === 1'b0) found = 1;
            else prev_irq = bus_if.irq;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL pol_fall_data: got %h expected 00000000 within %0d cycles",
                     bus_if.rd_data, 5 * TD);
        end
        // DATA and EDGE update on the same edge, so irq rises together with
        // the DATA read and was low the cycle before.
        n_vec++;
        if (bus_if.irq !== 1'b1 || prev_irq !== 1'b0) begin
            n_err++;
            $display("FAIL pol_fall_irq: got now=%b before=%b expected now=1 before=0",
                     bus_if.irq, prev_irq);
        end
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h1) begin
            n_err++;
            $display("FAIL pol_fall_edge: got %h expected 00000001", rv);
        end
    endtask

    task automatic test_w1c();
        logic [WS-1:0] rv;
        apply_reset('0);
        write_reg(SEL_MASK, 32'h1);
        pins = 32'h3;
        wait_cycles(4 * TD);
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h3 || bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_setup: got edge=%h irq=%b expected edge=00000003 irq=1",
                     rv, bus_if.irq);
        end
        write_reg(SEL_EDGE, 32'h1);
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h2 || bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_bit0: got edge=%h irq=%b expected edge=00000002 irq=0",
                     rv, bus_if.irq);
        end
        write_reg(SEL_MASK, 32'h2);
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h2 || bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL mask_change: got edge=%h irq=%b expected edge=00000002 irq=1",
                     rv, bus_if.irq);
        end
        write_reg(SEL_EDGE, 32'h2);
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h0 || bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_bit1: got edge=%h irq=%b expected edge=00000000 irq=0",
                     rv, bus_if.irq);
        end
        write_reg(SEL_DATA, 32'h0);
        read_reg(SEL_DATA, rv);
        n_vec++;
        if (rv !== 32'h3) begin
            n_err++;
            $display("FAIL data_write_ignored: got %h expected 00000003", rv);
        end
    endtask

    task automatic test_collision();
        logic [WS-1:0] rv;
        // Pin 4 high from reset: samples land on ticks at cycles 16, 32, 48
        // after release, so EDGE[4] sets on the 48th rising edge.
        apply_reset(32'h10);
        wait_cycles(3 * TD - 1);
        bus_if.sel     = SEL_EDGE;
        bus_if.we      = 1'b1;
        bus_if.wr_data = 32'h10;
        @(negedge clk);
        bus_if.we      = 1'b0;
        bus_if.wr_data = '0;
        n_vec++;
        if (bus_if.rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL collision_pre: got %h expected 00000000", bus_if.rd_data);
        end
        @(negedge clk);
        n_vec++;
        if (bus_if.rd_data !== 32'h10) begin
            n_err++;
            $display("FAIL collision_set_wins: got %h expected 00000010", bus_if.rd_data);
        end
        read_reg(SEL_DATA, rv);
        n_vec++;
        if (rv !== 32'h10) begin
            n_err++;
            $display("FAIL collision_data: got %h expected 00000010", rv);
        end
    endtask

    task automatic test_async_reset();
        logic [WS-1:0] rv;
        apply_reset(32'h8);
        wait_cycles(4 * TD);
        write_reg(SEL_MASK, 32'h8);
        read_reg(SEL_EDGE, rv);
        n_vec++;
        if (rv !== 32'h8 || bus_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL areset_setup: got edge=%h irq=%b expected edge=00000008 irq=1",
                     rv, bus_if.irq);
        end
        // Pin 2 collects a partial run of high samples, then reset lands
        // between clock edges.
        pins = 32'h4;
        wait_cycles(2 * TD + 8);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus_if.rd_data !== 32'h0 || bus_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL areset_immediate: got rd=%h irq=%b expected rd=00000000 irq=0",
                     bus_if.rd_data, bus_if.irq);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        // Only two post-release samples by cycle 40: no edge yet.
        wait_cycles(40);
        n_vec++;
        if (bus_if.rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL areset_no_spurious: got %h expected 00000000", bus_if.rd_data);
        end
        wait_cycles(10);
        n_vec++;
        if (bus_if.rd_data !== 32'h4) begin
            n_err++;
            $display("FAIL areset_late_edge: got %h expected 00000004", bus_if.rd_data);
        end
    endtask

    initial begin
        bus_if.sel     = SEL_DATA;
        bus_if.we      = 1'b0;
        bus_if.wr_data = '0;
        test_reset();
        test_debounce();
        test_polarity();
        test_w1c();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_input.md
GPIO_INPUT -- requirements
Module: gpio_input

Interface
REQ-001 Parameter WORD_SIZE, default 32, width of pin bank and data bus.
REQ-002 Parameter TICK_DIV, default 16, clk cycles between debounce sample ticks; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pins  input  WORD_SIZE  external pins, asynchronous to clk.
REQ-006 sel  input  2  register select from memory stage: 0 DATA, 1 EDGE, 2 MASK, 3 POLARITY.
REQ-007 we  input  1  write strobe for selected register.
REQ-008 wr_data  input  WORD_SIZE  write data.
REQ-009 rd_data  output  WORD_SIZE  registered read data.
REQ-010 irq  output  1  registered interrupt request.

Function
REQ-011 Each pin passes through a 2-flop synchronizer before any other use.
REQ-012 Tick counter counts 0..TICK_DIV-1 and wraps; tick asserts one cycle when count equals TICK_DIV-1.
REQ-013 On each tick, a per-bit 3-deep shift register samples the synchronized pin.
REQ-014 DATA bit updates only on a tick, and only when all 3 samples agree and differ from the current DATA bit; otherwise it holds.
REQ-015 Qualified edge: DATA bit changes 0->1 with POLARITY bit 1, or 1->0 with POLARITY bit 0.
REQ-016 A qualified edge sets the EDGE bit in the cycle DATA updates; EDGE bits are sticky.
REQ-017 Write to sel=1 clears each EDGE bit whose wr_data bit is 1 (write-1-to-clear); 0 bits are unaffected.
REQ-018 Set and clear of the same EDGE bit in the same cycle: set wins, bit reads 1.
REQ-019 Write to sel=2 loads MASK; write to sel=3 loads POLARITY; write to sel=0 is ignored.
REQ-020 rd_data <= selected register every clock, unconditionally: one-cycle read latency, matching the write-back pipeline register timing.
REQ-021 rd_data for sel=1 reflects EDGE before any same-cycle write takes effect.
REQ-022 irq <= |(EDGE & MASK) every clock; irq asserts one cycle after EDGE bit sets, deasserts one cycle after clear.
REQ-023 MASK change alone never sets or clears EDGE bits.

Reset
REQ-024 rst_n low clears synchronizers, shift registers, tick counter, DATA, EDGE, MASK, rd_data, irq to 0; POLARITY resets to all 1s (rising).
REQ-025 Reset mid-debounce discards partial samples; no edge is recorded for pins high at reset release until they debounce to 1 (rising edge then recorded).
REQ-026 Deassertion needs no special sequencing; first tick occurs TICK_DIV cycles after release.

Structure
REQ-027 Register select encodings (DATA, EDGE, MASK, POLARITY) are localparams in a shared package also used by the memory-stage address decode.
REQ-028 One sub-module, gpio_debounce, holds per-bit synchronizer and shift register, instantiated by generate per bit; tick counter stays in gpio_input.
REQ-029 No latches; single always block per register group; total 120-400 lines.

Verification
REQ-030 Reset: hold rst_n low, pins=32'hFFFF_FFFF -> rd_data=0, irq=0; after release, DATA reads 32'hFFFF_FFFF within 2+3*TICK_DIV+2 cycles and EDGE=32'hFFFF_FFFF.
REQ-031 Debounce: pin 0 glitches high for 1 tick period (TICK_DIV=16) -> DATA[0] stays 0, EDGE[0] stays 0; held high 4 tick periods -> DATA[0]=1, EDGE[0]=1.
REQ-032 Polarity: POLARITY=0, MASK=1, pin 0 rises then falls -> EDGE[0] sets only on fall; irq high one cycle later.
REQ-033 W1C: EDGE=32'h0000_0003, write sel=1 wr_data=32'h1 -> EDGE reads 32'h2 next cycle; irq follows MASK.
REQ-034 Collision: force qualified edge on bit 4 in same cycle as W1C of bit 4 -> EDGE[4]=1.
REQ-035 Async reset pulse mid-debounce with pin 2 toggling -> all outputs 0 immediately, no spurious EDGE after release until pin stable 3 ticks.
